// File: rtl/tone_seq_pkg.sv
// Shared types and default sizing for the tone sequencer slice.
package tone_seq_pkg;

    localparam int unsigned DEF_CNT_W     = 24;
    localparam int unsigned DEF_NUM_STEPS = 8;
    localparam int unsigned DEF_IDX_W     = $clog2(DEF_NUM_STEPS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] half_period;
        logic [7:0]           repeats;
    } step_entry_t;

    // A repeat count of zero plays the step once.
    function automatic logic [7:0] eff_repeats(input logic [7:0] r);
        return (r == 8'd0) ? 8'd1 : r;
    endfunction

endpackage

// File: rtl/half_period_divider.sv
// Loadable down-counter; tick marks the last cycle of a half period.
module half_period_divider
    import tone_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/tone_sequencer.sv
// Programmable square-wave tone sequencer: steps through a table of
// {half_period, repeats} entries and drives a single square-wave output.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 12000000,
    parameter int unsigned NUM_STEPS       = DEF_NUM_STEPS,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    localparam int unsigned IDX_W          = $clog2(NUM_STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0] cfg_half_period,
    input  logic [7:0]       cfg_repeats,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] step_idx,
    output logic             sq_wave
);

    typedef struct packed {
        logic [CNT_W-1:0] half_period;
        logic [7:0]       repeats;
    } entry_t;

    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(CLOCK_FREQUENCY / 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

    entry_t           step_tbl [NUM_STEPS];
    entry_t           cur;
    seq_state_t       state;
    logic [CNT_W-1:0] reload;
    logic [7:0]       remaining;
    logic             div_load;
    logic [CNT_W-1:0] div_load_val;
    logic             tick;

    assign cur = step_tbl[step_idx];

    // Step table: reset restores a single 1 Hz period; writes only while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                step_tbl[i] <= (i == 0) ? entry_t'{DEF_HALF, 8'd1} : '0;
            end
        end else if (cfg_we && !busy) begin
            step_tbl[cfg_addr] <= entry_t'{cfg_half_period, cfg_repeats};
        end
    end

    // Divider reload: a fresh half period on LOAD, the stored one on every RUN tick.
    always_comb begin
        div_load     = 1'b0;
        div_load_val = reload;
        if (state == LOAD) begin
            div_load     = 1'b1;
            div_load_val = cur.half_period - CNT_W'(1);
        end else if (state == RUN && tick) begin
            div_load = 1'b1;
        end
    end

    half_period_divider #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .load_val (div_load_val),
        .tick     (tick)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sq_wave   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
            remaining <= '0;
            reload    <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                sq_wave  <= 1'b0;
                busy     <= 1'b0;
                step_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sq_wave <= 1'b0;
                        if (start) begin
                            state    <= LOAD;
                            busy     <= 1'b1;
                            step_idx <= '0;
                        end
                    end
                    LOAD: begin
                        if (cur.half_period == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            sq_wave <= 1'b0;
                        end else begin
                            state     <= RUN;
                            sq_wave   <= 1'b1;
                            reload    <= cur.half_period - CNT_W'(1);
                            remaining <= eff_repeats(cur.repeats);
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (sq_wave) begin
                                sq_wave <= 1'b0;
                            end else if (remaining > 8'd1) begin
                                remaining <= remaining - 8'd1;
                                sq_wave   <= 1'b1;
                            end else if (step_idx == LAST_IDX) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                step_idx <= step_idx + IDX_W'(1);
                                state    <= LOAD;
                            end
                        end
                    end
                    DONE: begin
                        sq_wave  <= 1'b0;
                        step_idx <= '0;
                        if (loop_en) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
